// File: rtl/c_ram_sequencer_pkg.sv
// Shared defaults, return-tag type and the controller's offset-address mapping
// for the ciphertext RAM sequencer.
package c_ram_sequencer_pkg;

    localparam int DATAWIDTH_DEF = 8;
    localparam int DATADEPTH_DEF = 16;
    localparam int ADDRW_DEF     = 21;
    localparam int RETURN_STAGES = 2;

    typedef struct packed {
        logic rd1;
        logic rd2;
    } ret_tag_t;

    // The controller subtracts 1 and maps 0 to depth-1, so we present p+1 wrapped.
    // depth is always a power of two, so the wrap is a mask.
    function automatic int unsigned offset_addr(input int unsigned p, input int unsigned depth);
        return (p + 1) & (depth - 1);
    endfunction

endpackage

// File: rtl/c_ram_return_pipe.sv
// Tag shift register that marks which read port owns the RAM output
// RETURN_STAGES cycles after a grant.
module c_ram_return_pipe
    import c_ram_sequencer_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  ret_tag_t tag_in,
    output ret_tag_t tag_out
);

    generate
        for (genvar gi = 0; gi < RETURN_STAGES; gi++) begin : g_stage
            ret_tag_t stage_reg;
            if (gi == 0) begin : g_head
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) stage_reg <= '0;
                    else        stage_reg <= tag_in;
                end
            end else begin : g_body
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) stage_reg <= '0;
                    else        stage_reg <= g_stage[gi-1].stage_reg;
                end
            end
        end
    endgenerate

    assign tag_out = g_stage[RETURN_STAGES-1].stage_reg;

endmodule

// File: rtl/c_ram_sequencer.sv
// Initiator for the ciphertext RAM controller: stream writes, FIFO drain on
// read port 1, random-access peek on read port 2, with fill-level tracking.
module c_ram_sequencer
    import c_ram_sequencer_pkg::*;
#(
    parameter int DATAWIDTH = DATAWIDTH_DEF,
    parameter int DATADEPTH = DATADEPTH_DEF,
    parameter int ADDRW     = ADDRW_DEF,
    parameter int PTRW      = $clog2(DATADEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [DATAWIDTH-1:0] in_data,
    output logic                 in_ready,
    input  logic                 rd1_req,
    output logic                 rd1_grant,
    output logic                 rd1_valid,
    output logic [DATAWIDTH-1:0] rd1_data,
    input  logic                 rd2_req,
    input  logic [PTRW:0]        rd2_addr,
    output logic                 rd2_grant,
    output logic                 rd2_err,
    output logic                 rd2_valid,
    output logic [DATAWIDTH-1:0] rd2_data,
    output logic                 write_ram,
    output logic                 read_ram_1,
    output logic                 read_ram_2,
    output logic [ADDRW-1:0]     write_address,
    output logic [ADDRW-1:0]     read_address_1,
    output logic [ADDRW-1:0]     read_address_2,
    output logic [DATAWIDTH-1:0] ram_din,
    input  logic [DATAWIDTH-1:0] ram_dout,
    output logic [PTRW:0]        count,
    output logic                 full,
    output logic                 empty
);

    localparam logic [PTRW:0] DEPTH_CNT = (PTRW+1)'(DATADEPTH);

    logic [PTRW-1:0]      wr_ptr_reg;
    logic [PTRW-1:0]      rd_ptr_reg;
    logic [PTRW:0]        count_reg;
    logic [DATAWIDTH-1:0] ram_din_reg;
    logic [DATAWIDTH-1:0] rd1_hold_reg;
    logic [DATAWIDTH-1:0] rd2_hold_reg;
    logic                 write_fire;
    logic                 rd2_in_range;
    ret_tag_t             issue_tag;
    ret_tag_t             return_tag;

    assign full  = (count_reg == DEPTH_CNT);
    assign empty = (count_reg == '0);

    // Everything is gated by rst_n so no strobe escapes while reset is held.
    assign in_ready     = rst_n && !full;
    assign write_fire   = in_valid && in_ready;
    assign rd2_in_range = (rd2_addr < DEPTH_CNT);
    assign rd1_grant    = rst_n && rd1_req && !empty && !write_fire;
    assign rd2_grant    = rst_n && rd2_req && rd2_in_range && !write_fire && !rd1_grant;
    assign rd2_err      = rst_n && rd2_req && !rd2_in_range;

    assign write_ram  = write_fire;
    assign read_ram_1 = rd1_grant;
    assign read_ram_2 = rd2_grant;

    assign write_address  = ADDRW'(offset_addr(32'(wr_ptr_reg), unsigned'(DATADEPTH)));
    assign read_address_1 = ADDRW'(offset_addr(32'(rd_ptr_reg), unsigned'(DATADEPTH)));
    assign read_address_2 = ADDRW'(rd2_addr);

    assign ram_din = ram_din_reg;
    assign count   = count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            ram_din_reg <= '0;
        end else begin
            if (write_fire) begin
                wr_ptr_reg  <= wr_ptr_reg + PTRW'(1);
                ram_din_reg <= in_data;
            end
            if (rd1_grant) rd_ptr_reg <= rd_ptr_reg + PTRW'(1);
            // Write outranks read1, so at most one of these fires per cycle.
            case ({write_fire, rd1_grant})
                2'b10:   count_reg <= count_reg + (PTRW+1)'(1);
                2'b01:   count_reg <= count_reg - (PTRW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign issue_tag.rd1 = rd1_grant;
    assign issue_tag.rd2 = rd2_grant;

    c_ram_return_pipe u_return_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .tag_in  (issue_tag),
        .tag_out (return_tag)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd1_hold_reg <= '0;
            rd2_hold_reg <= '0;
        end else begin
            if (return_tag.rd1) rd1_hold_reg <= ram_dout;
            if (return_tag.rd2) rd2_hold_reg <= ram_dout;
        end
    end

    assign rd1_valid = return_tag.rd1;
    assign rd2_valid = return_tag.rd2;
    assign rd1_data  = return_tag.rd1 ? ram_dout : rd1_hold_reg;
    assign rd2_data  = return_tag.rd2 ? ram_dout : rd2_hold_reg;

endmodule

// File: tb/tb_c_ram_sequencer.sv
// Directed bench for c_ram_sequencer: a RAM-controller stand-in, a FIFO/shadow
// memory model checked every cycle, and hand-computed literal expectations.
module tb_c_ram_sequencer;

    localparam int DW = 8;
    localparam int DEPTH = 16;
    localparam int AW = 21;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          rd1_req, rd1_grant, rd1_valid;
    logic [DW-1:0] rd1_data;
    logic          rd2_req, rd2_grant, rd2_err, rd2_valid;
    logic [PW:0]   rd2_addr;
    logic [DW-1:0] rd2_data;
    logic          write_ram, read_ram_1, read_ram_2;
    logic [AW-1:0] write_address, read_address_1, read_address_2;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout = '0;
    logic [PW:0]   count;
    logic          full, empty;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    c_ram_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .rd1_req(rd1_req), .rd1_grant(rd1_grant), .rd1_valid(rd1_valid), .rd1_data(rd1_data),
        .rd2_req(rd2_req), .rd2_addr(rd2_addr), .rd2_grant(rd2_grant), .rd2_err(rd2_err),
        .rd2_valid(rd2_valid), .rd2_data(rd2_data),
        .write_ram(write_ram), .read_ram_1(read_ram_1), .read_ram_2(read_ram_2),
        .write_address(write_address), .read_address_1(read_address_1),
        .read_address_2(read_address_2),
        .ram_din(ram_din), .ram_dout(ram_dout),
        .count(count), .full(full), .empty(empty)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- RAM controller stand-in ----------------
    logic [DW-1:0] env_mem [DEPTH];
    logic          wr_pend = 1'b0, rd_pend = 1'b0;
    logic [PW-1:0] wr_a = '0, rd_a = '0;

    function automatic logic [PW-1:0] unmap(input logic [AW-1:0] a);
        return (a == 0) ? PW'(DEPTH - 1) : PW'(a - 1);
    endfunction

    initial for (int i = 0; i < DEPTH; i++) env_mem[i] = '0;

    always @(posedge clk) begin
        if (wr_pend) env_mem[wr_a] <= ram_din;
        if (rd_pend) ram_dout <= env_mem[rd_a];
        wr_pend <= write_ram;
        wr_a    <= unmap(write_address);
        rd_pend <= read_ram_1 | read_ram_2;
        rd_a    <= read_ram_1 ? unmap(read_address_1) : read_address_2[PW-1:0];
    end

    // ---------------- behavioural model + per-cycle compare ----------------
    typedef struct {
        int            due;
        bit            is1;
        logic [DW-1:0] d;
    } pend_t;

    logic [DW-1:0] fifo_q [$];
    pend_t         pend [$];
    pend_t         keep [$];
    logic [DW-1:0] shadow [DEPTH];
    int            cyc = 0;
    int            wcnt = 0;
    int            pcnt = 0;
    logic [DW-1:0] last1 = '0, last2 = '0, last_din = '0;
    bit            e_full, e_wr, e_g1, e_g2, e_err, e_v1, e_v2;

    initial for (int i = 0; i < DEPTH; i++) shadow[i] = '0;

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            fifo_q.delete(); pend.delete();
            wcnt = 0; pcnt = 0; last1 = '0; last2 = '0; last_din = '0;
            chk("rst_write_ram", write_ram, 0);
            chk("rst_read_ram_1", read_ram_1, 0);
            chk("rst_read_ram_2", read_ram_2, 0);
            chk("rst_rd1_valid", rd1_valid, 0);
            chk("rst_rd2_valid", rd2_valid, 0);
            chk("rst_rd2_err", rd2_err, 0);
            chk("rst_count", count, 0);
            chk("rst_rd1_data", rd1_data, 0);
            chk("rst_ram_din", ram_din, 0);
        end else begin
            e_full = (fifo_q.size() == DEPTH);
            e_wr   = in_valid && !e_full;
            e_g1   = rd1_req && fifo_q.size() > 0 && !e_wr;
            e_err  = rd2_req && rd2_addr >= DEPTH;
            e_g2   = rd2_req && !e_err && !e_wr && !e_g1;
            chk("cmp_count", count, fifo_q.size());
            chk("cmp_full", full, e_full);
            chk("cmp_empty", empty, fifo_q.size() == 0);
            chk("cmp_in_ready", in_ready, !e_full);
            chk("cmp_write_ram", write_ram, e_wr);
            chk("cmp_rd1_grant", rd1_grant, e_g1);
            chk("cmp_read_ram_1", read_ram_1, e_g1);
            chk("cmp_rd2_grant", rd2_grant, e_g2);
            chk("cmp_read_ram_2", read_ram_2, e_g2);
            chk("cmp_rd2_err", rd2_err, e_err);
            chk("cmp_write_address", write_address, (wcnt + 1) % DEPTH);
            chk("cmp_read_address_1", read_address_1, (pcnt + 1) % DEPTH);
            chk("cmp_read_address_2", read_address_2, rd2_addr);
            chk("cmp_ram_din", ram_din, last_din);
            e_v1 = 0; e_v2 = 0;
            keep.delete();
            foreach (pend[i]) begin
                if (pend[i].due == cyc) begin
                    if (pend[i].is1) begin e_v1 = 1; last1 = pend[i].d; end
                    else             begin e_v2 = 1; last2 = pend[i].d; end
                end else keep.push_back(pend[i]);
            end
            pend = keep;
            chk("cmp_rd1_valid", rd1_valid, e_v1);
            chk("cmp_rd1_data", rd1_data, last1);
            chk("cmp_rd2_valid", rd2_valid, e_v2);
            chk("cmp_rd2_data", rd2_data, last2);
            // commit what the next rising edge does
            if (e_wr) begin
                fifo_q.push_back(in_data);
                shadow[wcnt % DEPTH] = in_data;
                wcnt = (wcnt + 1) % DEPTH;
                last_din = in_data;
            end
            if (e_g1) begin
                pend.push_back('{due: cyc + 2, is1: 1'b1, d: fifo_q.pop_front()});
                pcnt = (pcnt + 1) % DEPTH;
            end
            if (e_g2) pend.push_back('{due: cyc + 2, is1: 1'b0, d: shadow[rd2_addr[PW-1:0]]});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 0; in_data = '0; rd1_req = 0; rd2_req = 0; rd2_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_count", count, 0);
        chk("reset_empty", empty, 1);
        chk("reset_write_ram", write_ram, 0);
        rst_n = 1'b1;

        // three writes
        for (int i = 0; i < 3; i++) begin
            step();
            in_valid = 1; in_data = 8'hA1 + 8'h11 * i[7:0];
            #1;
            chk("t1_write_address", write_address, i + 1);
            chk("t1_write_ram", write_ram, 1);
            $display("write data=%h addr=%0d", in_data, write_address);
        end
        step(); in_valid = 0; #1;
        chk("t1_count", count, 3);
        chk("t1_empty", empty, 0);

        // fill to 16
        for (int i = 3; i < DEPTH; i++) begin
            step();
            in_valid = 1; in_data = 8'h10 + i[7:0];
            #1;
            if (i == DEPTH - 1) chk("fill_last_write_address", write_address, 0);
            $display("write data=%h addr=%0d", in_data, write_address);
        end
        step(); #1;
        chk("fill_full", full, 1);
        chk("fill_in_ready", in_ready, 0);
        chk("fill_blocked_write", write_ram, 0);
        step(); #1;
        chk("fill_blocked_write2", write_ram, 0);
        in_valid = 0;

        // drain all 16
        for (int k = 0; k < DEPTH; k++) begin
            step();
            rd1_req = 1; #1;
            chk("drain_read_address_1", read_address_1, (k + 1) % DEPTH);
            chk("drain_grant", rd1_grant, 1);
            if (k == 2) begin
                chk("drain_first_valid", rd1_valid, 1);
                chk("drain_first_data", rd1_data, 8'hA1);
            end
            $display("pop grant addr=%0d", read_address_1);
        end
        step(); #1;
        chk("drain_empty", empty, 1);
        chk("drain_no_grant", rd1_grant, 0);
        rd1_req = 0;
        step(); step();

        // simultaneous requests with count=2
        for (int i = 0; i < 2; i++) begin
            step(); in_valid = 1; in_data = 8'h20 + i[7:0];
        end
        step();
        in_valid = 1; in_data = 8'h22; rd1_req = 1; rd2_req = 1; rd2_addr = 5'd3; #1;
        chk("arb_count_before", count, 2);
        chk("arb_write_wins", write_ram, 1);
        chk("arb_rd1_loses", rd1_grant, 0);
        chk("arb_rd2_loses", rd2_grant, 0);
        step(); in_valid = 0; #1;
        chk("arb_count_after", count, 3);
        chk("arb_rd1_next", rd1_grant, 1);
        chk("arb_rd2_still_loses", rd2_grant, 0);
        step(); rd1_req = 0; #1;
        chk("arb_rd2_last", rd2_grant, 1);
        chk("arb_read_ram_2", read_ram_2, 1);
        $display("arbitration sequence write, rd1, rd2");
        step(); rd2_req = 0;

        // peek 0x55 written at address 5
        for (int i = 0; i < 3; i++) begin
            step(); in_valid = 1; in_data = 8'h33 + 8'h11 * i[7:0];
        end
        step();
        in_valid = 0; rd2_req = 1; rd2_addr = 5'd5; #1;
        chk("peek_read_address_2", read_address_2, 5);
        chk("peek_grant", rd2_grant, 1);
        chk("peek_count", count, 5);
        step(); rd2_req = 0;
        step(); #1;
        chk("peek_valid", rd2_valid, 1);
        chk("peek_data", rd2_data, 8'h55);
        chk("peek_count_unchanged", count, 5);
        $display("peek addr=5 data=%h", rd2_data);
        step(); rd2_req = 1; rd2_addr = 5'd16; #1;
        chk("peek_err", rd2_err, 1);
        chk("peek_err_no_strobe", read_ram_2, 0);
        chk("peek_err_no_grant", rd2_grant, 0);
        step(); rd2_req = 0; #1;
        chk("peek_err_pulse_end", rd2_err, 0);

        // async reset one cycle after a pop grant
        step(); rd1_req = 1; #1;
        chk("rstflight_grant", rd1_grant, 1);
        step(); rd1_req = 0; in_valid = 1; rst_n = 1'b0; #1;
        chk("rstflight_count", count, 0);
        chk("rstflight_write_ram", write_ram, 0);
        chk("rstflight_rd1_valid", rd1_valid, 0);
        step(); #1;
        chk("rstflight_rd1_valid_t2", rd1_valid, 0);
        in_valid = 0;
        step(); rst_n = 1'b1;
        step(); in_valid = 1; in_data = 8'h77; #1;
        chk("after_rst_write_address", write_address, 1);
        chk("after_rst_read_address_1", read_address_1, 1);
        $display("write data=%h addr=%0d", in_data, write_address);
        step(); in_valid = 0; #1;
        chk("after_rst_count", count, 1);
        step(); rd1_req = 1;
        step(); rd1_req = 0;
        step(); #1;
        chk("after_rst_pop_valid", rd1_valid, 1);
        chk("after_rst_pop_data", rd1_data, 8'h77);
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/c_ram_sequencer.md
Name: c_ram_sequencer

Overview:
Initiator for the ciphertext RAM controller. It turns a valid/ready word stream into write requests, a FIFO-style drain port (read port 1) into sequential read requests, and a random-access peek port (read port 2) into addressed read requests. It returns read data with a tag-aligned valid, and tracks fill level so the circular buffer never overwrites unread words. It sits between the RSA encrypt output / UART transmit logic and the RAM controller.

Parameters:
DATAWIDTH, 8, RAM word width
DATADEPTH, 16, RAM depth in words (power of two, at least 2)
ADDRW, 21, address width presented to the controller
PTRW, $clog2(DATADEPTH), internal pointer width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  producer has word
in_data  in  DATAWIDTH  producer word
in_ready  out  1  word accepted this cycle when in_valid&&in_ready
rd1_req  in  1  drain next word (FIFO pop)
rd1_grant  out  1  pop accepted this cycle
rd1_valid  out  1  pop data valid
rd1_data  out  DATAWIDTH  pop data
rd2_req  in  1  peek request
rd2_addr  in  PTRW+1  peek absolute RAM address
rd2_grant  out  1  peek accepted this cycle
rd2_err  out  1  one-cycle pulse: rd2_addr >= DATADEPTH
rd2_valid  out  1  peek data valid
rd2_data  out  DATAWIDTH  peek data
write_ram, read_ram_1, read_ram_2  out  1 each  request strobes to controller
write_address, read_address_1, read_address_2  out  ADDRW each  controller addresses
ram_din  out  DATAWIDTH  registered write data to RAM
ram_dout  in  DATAWIDTH  synchronous-read RAM output
count  out  PTRW+1  words stored, 0..DATADEPTH
full, empty  out  1 each  count==DATADEPTH / count==0

Behaviour:
- Reset (async, rst_n=0): wr_ptr=0, rd_ptr=0, count=0, ram_din=0. All strobes, grants, valids and rd2_err are 0. Data outputs are 0. The two-stage return pipeline is cleared, so in-flight reads are dropped.
- Strobes are combinational from the current requests and registered state. Priority is write > read1 > read2, matching the controller.
- in_ready = !full. Write fires when in_valid && !full: write_ram=1, and ram_din<=in_data on that edge, so it is valid while the controller registers the address.
- write_address = (wr_ptr+1) mod DATADEPTH, zero-extended. The controller subtracts 1 and maps 0 to DATADEPTH-1, so the RAM writes at wr_ptr.
- read_address_1 = (rd_ptr+1) mod DATADEPTH, using the same offset convention.
- read_address_2 = rd2_addr, zero-extended; the controller uses it unmodified.
- rd1_grant = rd1_req && !empty && !write_fire. read_ram_1=rd1_grant. rd_ptr advances on grant.
- rd2_grant = rd2_req && rd2_addr<DATADEPTH && !write_fire && !rd1_grant. Peek does not change pointers or count, and may read unwritten/stale locations.
- rd2_err = rd2_req && rd2_addr>=DATADEPTH. It is a one-cycle pulse, and no strobe is issued.
- A request that loses arbitration gets grant=0. The requester holds the request; no queuing.
- Pointers wrap DATADEPTH-1 -> 0.
- count: +1 on write only, -1 on rd1_grant only, unchanged on both or neither. Both can never occur in one cycle, since write has priority.
- Read latency: grant at cycle T, controller address at T+1, RAM output at T+2. A 2-deep tag shift register {rd1,rd2} flags the return. At T+2, rdX_valid=1 and rdX_data=ram_dout (registered capture is not required; output is combinational from the tag).
- rd1_data and rd2_data hold their last value when not valid.
- Back-to-back grants every cycle are legal; throughput is 1 access/cycle total.

Decomposition:
- Shared package: DATAWIDTH/DATADEPTH/ADDRW defaults, and the offset-address function ((p+1) mod DATADEPTH) shared with the controller's inverse mapping.
- Sub-module: c_ram_return_pipe, the 2-stage tag/valid shift register with async active-low clear.

Test Plan:
- Reset then write 0xA1,0xB2,0xC3 -> write_address 1,2,3. RAM holds the words at 0,1,2. count=3, empty=0.
- Fill: 16 writes -> full=1, in_ready=0. 17th in_valid held produces no write_ram. wr_ptr wraps: 16th write has write_address=0, and the RAM stores at 15.
- Drain after fill: rd1_req for 16 cycles -> read_address_1 1..15,0. rd1_valid two cycles after each grant with data in write order. empty=1 after the last grant, and rd1_req then gives no grant.
- Simultaneous in_valid, rd1_req, rd2_req with count=2 -> only write_ram=1, count=3. The next cycle without in_valid gives rd1_grant; the cycle after gives rd2_grant.
- Peek rd2_addr=5 after writing 0x55 there -> read_address_2=5, rd2_valid at T+2 with 0x55, count unchanged. rd2_addr=16 -> rd2_err pulse, no strobe.
- Assert rst_n=0 one cycle after rd1_grant -> rd1_valid never asserts. count=0, pointers 0, all strobes 0 immediately (asynchronous).
